// File: rtl/oled_frame_arbiter_if.sv
// ----------------------------------------------------------------------------
// oled_frame_arbiter_if
// Groups the per-frame handshake and pixel bus between the task controllers,
// Oled_Display and oled_frame_arbiter.
//   frame_begin    : single-cycle start-of-frame pulse from Oled_Display
//   req            : per-source request levels (asynchronous to clk)
//   src_pixel_data : source i on bits [16i+15:16i], RGB565
//   pixel_data     : selected pixel towards Oled_Display
//   grant          : one-hot active source, zero unless a source owns the display
//   switching      : high while blank frames are shown between sources
// Modports: master = the side that drives the sources and the display pulse,
//           slave  = the arbiter.
// ----------------------------------------------------------------------------
interface oled_frame_arbiter_if #(
    parameter int N_SRC = 4
) ();
    logic                   frame_begin;
    logic [N_SRC-1:0]       req;
    logic [16*N_SRC-1:0]    src_pixel_data;
    logic [15:0]            pixel_data;
    logic [N_SRC-1:0]       grant;
    logic                   switching;

    modport master (
        output frame_begin,
        output req,
        output src_pixel_data,
        input  pixel_data,
        input  grant,
        input  switching
    );

    modport slave (
        input  frame_begin,
        input  req,
        input  src_pixel_data,
        output pixel_data,
        output grant,
        output switching
    );
endinterface

// File: rtl/oled_frame_arbiter.sv
// ----------------------------------------------------------------------------
// oled_frame_arbiter
// Shares the 96x64 OLED pixel stream among N_SRC pixel sources. The owning
// source only changes on a frame_begin pulse, so frames are never torn, and a
// source change is padded with BLANK_FRAMES frames of BLANK_COLOR.
//
// Ports:
//   clk     : OLED pixel clock (6.25 MHz), single clock domain
//   reset_n : asynchronous, active-low reset
//   bus     : oled_frame_arbiter_if.slave (frame_begin, req, src_pixel_data in;
//             pixel_data, grant, switching out)
//
// Build option:
//   OLED_ARB_ROUND_ROBIN_EN : round-robin rotation with HOLD_FRAMES dwell time.
//   Left undefined, the lowest requesting index always wins (fixed priority).
// ----------------------------------------------------------------------------
module oled_frame_arbiter #(
    parameter int          N_SRC        = 4,
    parameter int          BLANK_FRAMES = 1,
    parameter int          HOLD_FRAMES  = 60,
    parameter logic [15:0] BLANK_COLOR  = 16'h0000,
    parameter logic [15:0] IDLE_COLOR   = 16'h0000
) (
    input logic                  clk,
    input logic                  reset_n,
    oled_frame_arbiter_if.slave  bus
);

    localparam int CUR_W = $clog2(N_SRC);

    if (N_SRC < 2 || N_SRC > 8) begin : g_bad_nsrc
        $error("oled_frame_arbiter: N_SRC must be 2..8");
    end
    if (BLANK_FRAMES < 0 || BLANK_FRAMES > 15) begin : g_bad_blank
        $error("oled_frame_arbiter: BLANK_FRAMES must be 0..15");
    end
    if (HOLD_FRAMES < 1 || HOLD_FRAMES > 255) begin : g_bad_hold
        $error("oled_frame_arbiter: HOLD_FRAMES must be 1..255");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BLANK  = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [CUR_W-1:0]   cur, cur_next;
    logic [3:0]         blank_cnt, blank_next;
    logic [N_SRC-1:0]   req_meta, req_s;
    logic [CUR_W-1:0]   entry_pick, active_pick, exit_pick;

    // First set index of r, scanning upward from 'from' with wrap-around.
    // With incl=0 the scan starts just above 'from' and visits 'from' last.
    function automatic logic [CUR_W-1:0] next_set(
        input logic [N_SRC-1:0] r,
        input logic [CUR_W-1:0] from,
        input logic             incl
    );
        logic [CUR_W-1:0] sel;
        logic [CUR_W-1:0] ix;
        logic             found;
        int               idx;
        sel   = from;
        found = 1'b0;
        for (int k = 0; k <= N_SRC; k++) begin
            idx = int'(from) + k;
            if (idx >= N_SRC) idx = idx - N_SRC;
            ix = idx[CUR_W-1:0];
            if (!found && (incl || k != 0) && r[ix]) begin
                sel   = ix;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // Request synchronizer: req is driven by switches in another domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_meta <= '0;
            req_s    <= '0;
        end else begin
            req_meta <= bus.req;
            req_s    <= req_meta;
        end
    end

`ifdef OLED_ARB_ROUND_ROBIN_EN
    logic [7:0] hold_cnt, hold_next;

    // Leaving IDLE, rotation restarts at the last owner itself so a freshly
    // reset arbiter still favours index 0. Leaving BLANK, the scan begins
    // above the previous owner, which is the one being rotated away from.
    always_comb begin
        entry_pick  = next_set(req_s, cur, 1'b1);
        exit_pick   = next_set(req_s, cur, 1'b0);
        active_pick = cur;
        if (!req_s[cur] ||
            (((req_s & ~(N_SRC'(1) << cur)) != '0) &&
             (hold_cnt == 8'(HOLD_FRAMES - 1)))) begin
            active_pick = next_set(req_s, cur, 1'b0);
        end
    end

    // hold_cnt restarts whenever a source newly owns the display.
    always_comb begin
        hold_next = hold_cnt;
        if (bus.frame_begin) begin
            if (state_next == ACTIVE && (state != ACTIVE || cur_next != cur)) begin
                hold_next = '0;
            end else if (state == ACTIVE && state_next == ACTIVE &&
                         hold_cnt != 8'hFF) begin
                hold_next = hold_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) hold_cnt <= '0;
        else          hold_cnt <= hold_next;
    end
`else
    always_comb begin
        entry_pick  = next_set(req_s, '0, 1'b1);
        active_pick = entry_pick;
        exit_pick   = entry_pick;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cur       <= '0;
            blank_cnt <= '0;
        end else begin
            state     <= state_next;
            cur       <= cur_next;
            blank_cnt <= blank_next;
        end
    end

    // Everything moves only on frame_begin, so outputs stay stable mid-frame.
    always_comb begin
        state_next = state;
        cur_next   = cur;
        blank_next = blank_cnt;
        if (bus.frame_begin) begin
            case (state)
                IDLE: begin
                    if (req_s != '0) begin
                        state_next = ACTIVE;
                        cur_next   = entry_pick;
                    end
                end
                ACTIVE: begin
                    if (req_s == '0) begin
                        state_next = IDLE;
                    end else if (active_pick != cur) begin
                        if (BLANK_FRAMES == 0) begin
                            cur_next = active_pick;
                        end else begin
                            state_next = BLANK;
                            blank_next = 4'(BLANK_FRAMES - 1);
                        end
                    end
                end
                BLANK: begin
                    if (blank_cnt != '0) begin
                        blank_next = blank_cnt - 4'd1;
                    end else if (req_s == '0) begin
                        state_next = IDLE;
                    end else begin
                        // Re-arbitrate: requests may have moved during blanking.
                        state_next = ACTIVE;
                        cur_next   = exit_pick;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Live source pixels pass straight through: no added pixel latency.
    always_comb begin
        bus.pixel_data = IDLE_COLOR;
        bus.grant      = '0;
        bus.switching  = 1'b0;
        case (state)
            ACTIVE: begin
                bus.pixel_data = bus.src_pixel_data[16*cur +: 16];
                bus.grant      = N_SRC'(1) << cur;
            end
            BLANK: begin
                bus.pixel_data = BLANK_COLOR;
                bus.switching  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_oled_frame_arbiter.sv
// ----------------------------------------------------------------------------
// tb_oled_frame_arbiter
// Directed and randomized stimulus for oled_frame_arbiter, checked against a
// frame-level behavioural model of ownership, blanking and idling.
// Build option OLED_ARB_ROUND_ROBIN_EN selects the round-robin configuration
// (HOLD_FRAMES=2, BLANK_FRAMES=0); otherwise fixed priority with BLANK_FRAMES=1.
// ----------------------------------------------------------------------------
module tb_oled_frame_arbiter;

    localparam int NS = 4;
`ifdef OLED_ARB_ROUND_ROBIN_EN
    localparam int BF = 0;
    localparam int HF = 2;
`else
    localparam int BF = 1;
    localparam int HF = 60;
`endif
    localparam logic [15:0] BC = 16'h0841;
    localparam logic [15:0] IC = 16'h0000;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    oled_frame_arbiter_if #(.N_SRC(NS)) bus ();

    oled_frame_arbiter #(
        .N_SRC(NS), .BLANK_FRAMES(BF), .HOLD_FRAMES(HF),
        .BLANK_COLOR(BC), .IDLE_COLOR(IC)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Request as the arbiter sees it: two clock edges of delay, cleared on reset.
    logic [NS-1:0] rq1, rq2;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rq1 <= '0;
            rq2 <= '0;
        end else begin
            rq1 <= bus.req;
            rq2 <= rq1;
        end
    end

    // Frame-level model: who owns the display, how many blank frames remain,
    // the last owner (rotation origin) and how long the owner has held.
    int m_owner;
    int m_left;
    int m_last;
    int m_hold;

    function automatic int rot(input logic [NS-1:0] r, input int from, input bit incl);
        for (int k = (incl ? 0 : 1); k <= NS; k++) begin
            if (r[(from + k) % NS]) return (from + k) % NS;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_left  = 0;
        m_last  = 0;
        m_hold  = 0;
    endtask

    task automatic take(input int w);
        m_owner = w;
        m_last  = w;
        m_hold  = 0;
    endtask

    task automatic model_frame(input logic [NS-1:0] r);
        int w;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && r != 0) begin
`ifdef OLED_ARB_ROUND_ROBIN_EN
                take(rot(r, m_last, 1'b0));
`else
                take(rot(r, 0, 1'b1));
`endif
            end
        end else if (m_owner < 0) begin
            if (r != 0) begin
`ifdef OLED_ARB_ROUND_ROBIN_EN
                take(rot(r, m_last, 1'b1));
`else
                take(rot(r, 0, 1'b1));
`endif
            end
        end else if (r == 0) begin
            m_owner = -1;
        end else begin
`ifdef OLED_ARB_ROUND_ROBIN_EN
            if (!r[m_owner] ||
                (((r & ~(4'b0001 << m_owner)) != 0) && m_hold == HF - 1))
                w = rot(r, m_owner, 1'b0);
            else
                w = m_owner;
`else
            w = rot(r, 0, 1'b1);
`endif
            if (w == m_owner) begin
                if (m_hold < 255) m_hold++;
            end else if (BF == 0) begin
                take(w);
            end else begin
                m_owner = -1;
                m_left  = BF;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] e_pix;
        logic [NS-1:0] e_gnt;
        if (m_owner >= 0) begin
            e_pix = bus.src_pixel_data[16*m_owner +: 16];
            e_gnt = NS'(1) << m_owner;
        end else begin
            e_pix = (m_left > 0) ? BC : IC;
            e_gnt = '0;
        end
        chk({tag, ".grant"}, 16'(bus.grant), 16'(e_gnt));
        chk({tag, ".switching"}, 16'(bus.switching), 16'(m_left > 0));
        chk({tag, ".pixel"}, bus.pixel_data, e_pix);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.src_pixel_data = {$urandom, $urandom};
            #1 check_all("gap");
        end
    endtask

    task automatic frame(input int gap);
        model_frame(rq2);
        bus.frame_begin = 1'b1;
        @(negedge clk);
        bus.frame_begin = 1'b0;
        check_all("frame");
        idle(gap);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_all("reset");
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n            = 1'b1;
        bus.frame_begin    = 1'b0;
        bus.req            = '0;
        bus.src_pixel_data = {$urandom, $urandom};
        model_reset();
        #1 reset_n = 1'b0;
        #1 check_all("rst0");
        chk("rst0.idle_color", bus.pixel_data, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);

        frame(3);

`ifdef OLED_ARB_ROUND_ROBIN_EN
        // Rotation between sources 0 and 3, two frames each.
        bus.req = 4'b1001;
        idle(3);
        frame(2); chk("rr.f1", 16'(bus.grant), 16'h0001);
        frame(2); chk("rr.f2", 16'(bus.grant), 16'h0001);
        frame(2); chk("rr.f3", 16'(bus.grant), 16'h0008);
        frame(2); chk("rr.f4", 16'(bus.grant), 16'h0008);
        frame(2); chk("rr.f5", 16'(bus.grant), 16'h0001);
        bus.req = 4'b0000;
        idle(3);
        frame(2);
        async_reset();
        idle(2);
`endif

        // Single request: source 2 owns the display, pixels pass live.
        bus.req = 4'b0100;
        idle(3);
        frame(2);
        chk("single.grant", 16'(bus.grant), 16'h0004);
        @(negedge clk);
        bus.src_pixel_data[47:32] = 16'hF800;
        #1 chk("single.pixel", bus.pixel_data, 16'hF800);
        bus.src_pixel_data[47:32] = 16'h07E0;
        #1 chk("single.pixel2", bus.pixel_data, 16'h07E0);

        // Higher-priority request arrives.
        bus.req = 4'b0110;
        idle(3);
        frame(2);
`ifndef OLED_ARB_ROUND_ROBIN_EN
        chk("preempt.switching", 16'(bus.switching), 16'h0001);
        chk("preempt.blank", bus.pixel_data, BC);
`endif
        frame(2);
`ifndef OLED_ARB_ROUND_ROBIN_EN
        chk("preempt.grant", 16'(bus.grant), 16'h0002);
`endif

        // Release to idle.
        bus.req = 4'b0000;
        idle(3);
        frame(2);
        chk("release.grant", 16'(bus.grant), 16'h0000);

        // One-cycle glitch well between pulses is never seen.
        @(negedge clk);
        bus.req = 4'b0001;
        @(negedge clk);
        bus.req = 4'b0000;
        idle(4);
        frame(2);
        chk("glitch.grant", 16'(bus.grant), 16'h0000);

        // Reset while blanking, then straight back to ACTIVE.
        bus.req = 4'b1000;
        idle(3);
        frame(2);
        bus.req = 4'b1100;
        idle(3);
        frame(1);
        async_reset();
        chk("rstblank.switching", 16'(bus.switching), 16'h0000);
        idle(3);
        frame(2);
`ifndef OLED_ARB_ROUND_ROBIN_EN
        chk("rstblank.grant", 16'(bus.grant), 16'h0004);
`endif
        chk("rstblank.noblank", 16'(bus.switching), 16'h0000);

        // Back-to-back frame pulses count as two frames.
        bus.req = 4'b0001;
        idle(3);
        frame(0);
        frame(0);
        frame(2);

        // Randomized traffic.
        for (int it = 0; it < 120; it++) begin
            int sel;
            sel = int'($urandom_range(0, 19));
            if (sel < 8) begin
                bus.req = NS'($urandom);
            end else if (sel == 8) begin
                @(negedge clk);
                bus.req = bus.req ^ NS'($urandom);
                @(negedge clk);
                bus.req = bus.req ^ NS'($urandom);
            end else if (sel == 9) begin
                async_reset();
            end
            idle(int'($urandom_range(0, 3)));
            frame(int'($urandom_range(0, 4)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/oled_frame_arbiter.md
# oled_frame_arbiter

Shares the single 96x64 OLED pixel stream among up to N_SRC pixel-generating task controllers, e.g. the task_R controller and its siblings. Sits between the task controllers and Oled_Display in the 6.25 MHz OLED clock domain. It drives the selected source's pixel_data onto the display and changes the selected source only on frame boundaries, so no frame is ever torn. On every source change it inserts one or more blank frames.

## Interface
Parameters:
- N_SRC, 4: number of pixel sources (2..8).
- BLANK_FRAMES, 1: blank frames inserted on a source change (0..15; 0 = direct switch).
- HOLD_FRAMES, 60: frames a source keeps the display before rotation (round-robin build only; 1..255).
- BLANK_COLOR, 16'h0000: RGB565 colour shown during blank frames.
- IDLE_COLOR, 16'h0000: RGB565 colour shown when no source requests.

Ports:
- clk, in, 1: OLED pixel clock (clk_6p25MHz). Single clock domain.
- reset_n, in, 1: asynchronous, active-low reset.
- frame_begin, in, 1: single-cycle pulse from Oled_Display at the start of each frame.
- req, in, N_SRC: request levels, typically from sw; asynchronous to clk.
- src_pixel_data, in, 16*N_SRC: source i occupies bits [16i+15:16i].
- pixel_data, out, 16: to Oled_Display.
- grant, out, N_SRC: one-hot active source; all zero when not ACTIVE.
- switching, out, 1: high while in BLANK.

## Operation
- req passes through a 2-flop synchronizer to give req_s. Reset value is 0.
- State, cur (the source index), blank_cnt and hold_cnt update only on a clk edge where frame_begin=1. Between pulses every output is stable.
- Winner selection, default: the lowest set index of req_s.
- States:
  - IDLE: pixel_data=IDLE_COLOR, grant=0. On frame_begin with req_s≠0: go to ACTIVE with cur=winner.
  - ACTIVE: pixel_data=src_pixel_data[cur], grant=1<<cur.
    - On frame_begin with req_s=0: go to IDLE.
    - On frame_begin with winner≠cur: if BLANK_FRAMES=0, set cur=winner and stay ACTIVE; otherwise go to BLANK with blank_cnt=BLANK_FRAMES-1.
    - Otherwise: stay ACTIVE and increment hold_cnt, saturating.
  - BLANK: pixel_data=BLANK_COLOR, grant=0, switching=1.
    - On frame_begin with blank_cnt≠0: decrement blank_cnt.
    - On frame_begin with blank_cnt=0: recompute the winner. If req_s=0, go to IDLE. Otherwise go to ACTIVE with cur=the fresh winner, not the winner that triggered BLANK.
- hold_cnt clears on every entry to ACTIVE and on every cur change.
- pixel_data is a combinational mux of registered state/cur and the live src_pixel_data. This adds zero pixel latency, so source x/y alignment is preserved.
- Reset, asynchronous and valid mid-frame or mid-BLANK:
  - state=IDLE, cur=0, blank_cnt=0, hold_cnt=0.
  - Outputs: grant=0, switching=0, pixel_data=IDLE_COLOR.

## Timing
- A req change reaches req_s after 2 clk edges. It acts at the first frame_begin after that.
- Worst-case selection latency is 2 cycles plus 1 frame, i.e. 6144 pixel cycles plus overhead.
- A source change appears on the display after 1+BLANK_FRAMES frame_begin pulses, counted from the first pulse that sees the new req_s.
- A req pulse that lies entirely between two frame_begin pulses is ignored.
- frame_begin asserted in back-to-back cycles counts as two frames.

## Configuration
- OLED_ARB_ROUND_ROBIN_EN defined:
  - Winner selection in ACTIVE: if req_s[cur]=1 and another bit is set, and hold_cnt=HOLD_FRAMES-1 at frame_begin, the winner is the next set index above cur, wrapping around.
  - If req_s[cur]=0, the winner is the next set index above cur, wrapping around.
  - IDLE and BLANK exit use the same rotation, starting from the last cur.
- Undefined: fixed priority, lowest index wins, and a higher-priority request pre-empts at the next frame_begin. hold_cnt is unused and may be optimized away.

## Test plan
- Reset: assert reset_n=0 mid-frame -> pixel_data=16'h0000 (IDLE_COLOR), grant=0, switching=0 immediately, with no clock needed.
- Single request: req=4'b0100, src2=16'hF800 -> grant=4'b0100 after the next frame_begin, and pixel_data tracks src2 with zero latency.
- Pre-emption with fixed priority and BLANK_FRAMES=1: req goes from 4'b0100 to 4'b0110 -> next frame switching=1 and pixel_data=BLANK_COLOR; the following frame grant=4'b0010.
- Release: in ACTIVE, req drops to 0 -> IDLE at the next frame_begin. A req glitch shorter than one frame between pulses produces no grant change.
- Reset mid-BLANK: reset_n pulsed low during BLANK -> IDLE immediately. With req still set, the first frame_begin after release goes straight to ACTIVE, with no blank frame.
- Round robin, with OLED_ARB_ROUND_ROBIN_EN, HOLD_FRAMES=2, BLANK_FRAMES=0: req=4'b1001 -> grant sequence per frame is 0001, 0001, 1000, 1000, 0001.
